// File: rtl/battle_hp_if.sv
// Strobe/result bundle between the battle control FSM and the HP datapath.
//   master : FSM side; drives move_in and the per-state level strobes,
//            reads HP, damage, busy, calc_done and hp_is_zero.
//   slave  : datapath side; the mirror image.
interface battle_hp_if #(
  parameter int unsigned HP_W = 8
);
  logic [1:0]      move_in;
  logic            ld_pm;
  logic            calc_ph;
  logic            apply_ad;
  logic            ld_am;
  logic            calc_ah;
  logic            apply_pd;
  logic [HP_W-1:0] player_hp;
  logic [HP_W-1:0] ai_hp;
  logic [HP_W-1:0] damage;
  logic            busy;
  logic            calc_done;
  logic            hp_is_zero;

  modport master (
    output move_in, ld_pm, calc_ph, apply_ad, ld_am, calc_ah, apply_pd,
    input  player_hp, ai_hp, damage, busy, calc_done, hp_is_zero
  );

  modport slave (
    input  move_in, ld_pm, calc_ph, apply_ad, ld_am, calc_ah, apply_pd,
    output player_hp, ai_hp, damage, busy, calc_done, hp_is_zero
  );
endinterface

// File: rtl/battle_hp_datapath.sv
// Battle HP datapath: holds player/AI HP, latches moves, computes damage
// with a 4-cycle shift-add multiplier and applies it on apply strobes.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : battle_hp_if slave (FSM strobes in; HP, damage, busy,
//           calc_done, hp_is_zero out)
module battle_hp_datapath #(
  parameter int unsigned HP_W    = 8,
  parameter int unsigned INIT_HP = 100,
  parameter logic [3:0]  P_ATK   = 4'd3,
  parameter logic [3:0]  A_ATK   = 4'd2
) (
  input logic         clk,
  input logic         reset,
  battle_hp_if.slave  bus
);

  // Accumulator must hold a full 4x4 product before saturation.
  localparam int unsigned AccW = (HP_W > 8) ? HP_W : 8;
  localparam logic [AccW-1:0] HpMax = AccW'((64'd1 << HP_W) - 64'd1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} mul_state_e;

  mul_state_e      state_q, state_d;
  logic [1:0]      pm_q, pm_d, am_q, am_d;
  logic [AccW-1:0] mcand_q, mcand_d, acc_q, acc_d, prod_sat;
  logic [3:0]      mplier_q, mplier_d;
  logic [1:0]      bit_q, bit_d;
  logic [HP_W-1:0] damage_q, damage_d, player_hp_q, player_hp_d, ai_hp_q, ai_hp_d;
  logic            calc_done_q, calc_done_d;
  logic            pending_q, pending_d, pend_ai_q, pend_ai_d;
  logic            calc_ph_q, calc_ah_q, apply_ad_q, apply_pd_q;
  logic            calc_ph_edge, calc_ah_edge, apply_ad_edge, apply_pd_edge;

  function automatic logic [3:0] power(input logic [1:0] m);
    logic [3:0] p;
    unique case (m)
      2'd0: p = 4'd4;
      2'd1: p = 4'd6;
      2'd2: p = 4'd8;
      default: p = 4'd10;
    endcase
    return p;
  endfunction

  function automatic logic [HP_W-1:0] sub_sat(input logic [HP_W-1:0] hp,
                                               input logic [HP_W-1:0] d);
    return (hp > d) ? hp - d : '0;
  endfunction

  assign calc_ph_edge  = bus.calc_ph  & ~calc_ph_q;
  assign calc_ah_edge  = bus.calc_ah  & ~calc_ah_q;
  assign apply_ad_edge = bus.apply_ad & ~apply_ad_q;
  assign apply_pd_edge = bus.apply_pd & ~apply_pd_q;

  always_comb begin
    prod_sat = (acc_q > HpMax) ? HpMax : acc_q;
  end

  always_comb begin
    state_d     = state_q;
    pm_d        = pm_q;
    am_d        = am_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    bit_d       = bit_q;
    acc_d       = acc_q;
    damage_d    = damage_q;
    player_hp_d = player_hp_q;
    ai_hp_d     = ai_hp_q;
    calc_done_d = 1'b0;
    pending_d   = pending_q;
    pend_ai_d   = pend_ai_q;

    if (bus.ld_pm) pm_d = bus.move_in;
    if (bus.ld_am) am_d = bus.move_in;

    unique case (state_q)
      StIdle: begin
        if (calc_ph_edge || calc_ah_edge) begin
          mcand_d  = calc_ph_edge ? AccW'(power(pm_q)) : AccW'(power(am_q));
          mplier_d = calc_ph_edge ? P_ATK : A_ATK;
          acc_d    = '0;
          bit_d    = '0;
          state_d  = StMul;
        end
        if (apply_ad_edge)      ai_hp_d     = sub_sat(ai_hp_q, damage_q);
        else if (apply_pd_edge) player_hp_d = sub_sat(player_hp_q, damage_q);
      end
      StMul: begin
        // Multiplicand shifts left as the multiplier shifts right, so each
        // step adds multiplicand << i for multiplier bit i.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        bit_d    = bit_q + 2'd1;
        if (bit_q == 2'd3) state_d = StDone;
        if (!pending_q) begin
          if (apply_ad_edge) begin
            pending_d = 1'b1;
            pend_ai_d = 1'b1;
          end else if (apply_pd_edge) begin
            pending_d = 1'b1;
            pend_ai_d = 1'b0;
          end
        end
      end
      StDone: begin
        damage_d    = prod_sat[HP_W-1:0];
        calc_done_d = 1'b1;
        state_d     = StIdle;
        // Deferred or same-cycle applies both use the fresh product.
        if (pending_q) begin
          if (pend_ai_q) ai_hp_d     = sub_sat(ai_hp_q, prod_sat[HP_W-1:0]);
          else           player_hp_d = sub_sat(player_hp_q, prod_sat[HP_W-1:0]);
          pending_d = 1'b0;
        end else if (apply_ad_edge) begin
          ai_hp_d = sub_sat(ai_hp_q, prod_sat[HP_W-1:0]);
        end else if (apply_pd_edge) begin
          player_hp_d = sub_sat(player_hp_q, prod_sat[HP_W-1:0]);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pm_q        <= '0;
      am_q        <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      bit_q       <= '0;
      acc_q       <= '0;
      damage_q    <= '0;
      player_hp_q <= HP_W'(INIT_HP);
      ai_hp_q     <= HP_W'(INIT_HP);
      calc_done_q <= 1'b0;
      pending_q   <= 1'b0;
      pend_ai_q   <= 1'b0;
      calc_ph_q   <= 1'b0;
      calc_ah_q   <= 1'b0;
      apply_ad_q  <= 1'b0;
      apply_pd_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pm_q        <= pm_d;
      am_q        <= am_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      bit_q       <= bit_d;
      acc_q       <= acc_d;
      damage_q    <= damage_d;
      player_hp_q <= player_hp_d;
      ai_hp_q     <= ai_hp_d;
      calc_done_q <= calc_done_d;
      pending_q   <= pending_d;
      pend_ai_q   <= pend_ai_d;
      calc_ph_q   <= bus.calc_ph;
      calc_ah_q   <= bus.calc_ah;
      apply_ad_q  <= bus.apply_ad;
      apply_pd_q  <= bus.apply_pd;
    end
  end

  assign bus.player_hp  = player_hp_q;
  assign bus.ai_hp      = ai_hp_q;
  assign bus.damage     = damage_q;
  assign bus.busy       = (state_q == StMul);
  assign bus.calc_done  = calc_done_q;
  assign bus.hp_is_zero = bus.apply_ad ? (ai_hp_q == '0) :
                          bus.apply_pd ? (player_hp_q == '0) : 1'b0;

endmodule

// File: tb/tb_battle_hp_datapath.sv
module tb_battle_hp_datapath;
  localparam int HP_W = 8;

  logic clk = 1'b0;
  logic reset;

  battle_hp_if #(.HP_W(HP_W)) bus ();

  battle_hp_datapath #(
    .HP_W(HP_W), .INIT_HP(100), .P_ATK(4'd3), .A_ATK(4'd2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int power_tab[4] = '{4, 6, 8, 10};
  int ai_m = 100;
  int pl_m = 100;
  int mon_e;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hit(input int hp, input int d);
    return (hp > d) ? hp - d : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every calc_done pulse must match the oldest expected damage.
  always @(negedge clk) begin
    if (!reset && bus.calc_done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL calc_done_extra: got pulse damage=%0d expected no pulse", bus.damage);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(bus.damage) != mon_e) begin
          bad++;
          $display("FAIL damage: got %0d expected %0d at %0t", bus.damage, mon_e, $time);
        end
      end
    end
  end

  task automatic do_reset();
    bus.ld_pm = 0; bus.ld_am = 0; bus.calc_ph = 0; bus.calc_ah = 0;
    bus.apply_ad = 0; bus.apply_pd = 0;
    reset = 1;
    tick();
    reset = 0;
    ai_m = 100;
    pl_m = 100;
    check("rst_ai_hp", bus.ai_hp, 100);
    check("rst_player_hp", bus.player_hp, 100);
    check("rst_damage", bus.damage, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_calc_done", bus.calc_done, 0);
    check("rst_hp_is_zero", bus.hp_is_zero, 0);
  endtask

  function automatic int target_hp(input bit ai_side);
    return ai_side ? int'(bus.ai_hp) : int'(bus.player_hp);
  endfunction

  // One attack turn. ai_side: player hits AI (ld_pm/calc_ph/apply_ad), else AI hits player.
  // k=0: apply after damage is ready; k=1..5: apply raised while the product is in flight.
  task automatic turn(input bit ai_side, input int mv, input int k, input bit both);
    int d, old_hp, new_hp, other_hp, hold;
    bus.move_in = 2'(mv);
    if (ai_side) bus.ld_pm = 1; else bus.ld_am = 1;
    repeat ($urandom_range(1, 3)) tick();
    bus.ld_pm = 0;
    bus.ld_am = 0;
    bus.move_in = 2'($urandom);  // must not disturb the latched move
    d = power_tab[mv] * (ai_side ? 3 : 2);
    if (d > 255) d = 255;
    old_hp   = ai_side ? ai_m : pl_m;
    other_hp = ai_side ? pl_m : ai_m;
    new_hp   = hit(old_hp, d);
    exp_q.push_back(d);
    if (ai_side) bus.calc_ph = 1; else bus.calc_ah = 1;
    hold = $urandom_range(8, 12);
    for (int i = 1; i <= hold; i++) begin
      tick();
      if (k != 0 && i == k) begin
        if (ai_side) bus.apply_ad = 1; else bus.apply_pd = 1;
      end
      check("busy", bus.busy, (i <= 4) ? 1 : 0);
      check("calc_done", bus.calc_done, (i == 6) ? 1 : 0);
      if (k != 0) check("hp_deferred", target_hp(ai_side), (i >= 6) ? new_hp : old_hp);
    end
    bus.calc_ph = 0;
    bus.calc_ah = 0;
    tick();
    if (k == 0) begin
      if (ai_side) bus.apply_ad = 1; else bus.apply_pd = 1;
      if (both) bus.apply_pd = 1;
      for (int i = 0; i < 3; i++) begin
        tick();
        check("hp_apply", target_hp(ai_side), new_hp);
        check("hp_is_zero", bus.hp_is_zero, (new_hp == 0) ? 1 : 0);
      end
    end else begin
      check("hp_after_defer", target_hp(ai_side), new_hp);
      check("hp_is_zero", bus.hp_is_zero, (new_hp == 0) ? 1 : 0);
    end
    check("hp_other_side", target_hp(!ai_side), other_hp);
    if (ai_side) ai_m = new_hp; else pl_m = new_hp;
    bus.apply_ad = 0;
    bus.apply_pd = 0;
    tick();
    check("hp_is_zero_idle", bus.hp_is_zero, 0);
  endtask

  initial begin
    bit side;
    int k;
    bus.move_in = 0;
    reset = 1;
    tick();
    do_reset();

    turn(1, 3, 0, 0);  // 30 damage: AI 100 -> 70
    turn(0, 0, 0, 0);  // 8 damage: player 100 -> 92
    turn(1, 3, 2, 0);  // deferred: AI 70 -> 40
    turn(1, 3, 0, 1);  // both applies: AI 40 -> 10, player untouched
    turn(1, 3, 5, 0);  // AI 10 -> 0, hp_is_zero

    // Reset in the middle of a multiply aborts it.
    bus.move_in = 2'd1;
    bus.ld_pm = 1;
    tick();
    bus.ld_pm = 0;
    bus.calc_ph = 1;
    repeat (3) tick();
    check("busy_mid_mul", bus.busy, 1);
    do_reset();
    repeat (8) tick();
    turn(1, 1, 0, 0);

    for (int n = 0; n < 40; n++) begin
      side = 1'($urandom);
      k = $urandom_range(0, 5);
      turn(side, $urandom_range(0, 3), k, (side && k == 0 && ($urandom % 4 == 0)));
      if ((ai_m == 0 || pl_m == 0) && ($urandom % 2 == 0)) do_reset();
    end

    repeat (4) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
